wb_regfile: RTL and testbench

//  Receiving end of the EX-stage register write interface (reg_we/wr_addr/rd_wdata).

---
 rtl/wb_regfile_if.sv | 31 +++
 rtl/wb_regfile.sv | 82 ++++++++
 tb/tb_wb_regfile.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_regfile_if : EX-stage write / decode-stage read bus of the register file |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              reg_we_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] rd_wdata_i;
  logic [ADDR_W-1:0] raddr_a_i;
  logic [ADDR_W-1:0] raddr_b_i;
  logic [DATA_W-1:0] rdata_a_o;
  logic [DATA_W-1:0] rdata_b_o;
  logic              wb_valid_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [DATA_W-1:0] wb_data_o;

  modport master (
    output reg_we_i, wr_addr_i, rd_wdata_i, raddr_a_i, raddr_b_i,
    input  rdata_a_o, rdata_b_o, wb_valid_o, wb_addr_o, wb_data_o
  );

  modport slave (
    input  reg_we_i, wr_addr_i, rd_wdata_i, raddr_a_i, raddr_b_i,
    output rdata_a_o, rdata_b_o, wb_valid_o, wb_addr_o, wb_data_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_regfile : 32-entry integer register file with a one-entry writeback     |
// |              stage and optional read forwarding of the pending entry       |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  wire logic    clk_i,
  input  wire logic    rst_ni,
  wb_regfile_if.slave  bus
);

  localparam int unsigned c_ENTRIES = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [c_ENTRIES];
  logic [DATA_W-1:0] regs_d [c_ENTRIES];
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;

  logic              hit_a, hit_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  // Capture of the new EX result and commit of the previous one share an edge.
  always_comb begin
    wb_valid_d = bus.reg_we_i && (bus.wr_addr_i != '0);
    wb_addr_d  = bus.wr_addr_i;
    wb_data_d  = bus.rd_wdata_i;
    regs_d     = regs_q;
    if (wb_valid_q) begin
      regs_d[wb_addr_q] = wb_data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(c_ENTRIES); i++) begin
        regs_q[i] <= '0;
      end
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      assign hit_a = wb_valid_q && (wb_addr_q == bus.raddr_a_i);
      assign hit_b = wb_valid_q && (wb_addr_q == bus.raddr_b_i);
    end else begin : g_no_bypass
      assign hit_a = 1'b0;
      assign hit_b = 1'b0;
    end
  endgenerate

  // Pending entry is always newer than the array copy, so it wins on a hit.
  always_comb begin
    rdata_a = regs_q[bus.raddr_a_i];
    rdata_b = regs_q[bus.raddr_b_i];
    if (hit_a) rdata_a = wb_data_q;
    if (hit_b) rdata_b = wb_data_q;
    if (bus.raddr_a_i == '0) rdata_a = '0;
    if (bus.raddr_b_i == '0) rdata_b = '0;
  end

  assign bus.rdata_a_o  = rdata_a;
  assign bus.rdata_b_o  = rdata_b;
  assign bus.wb_valid_o = wb_valid_q;
  assign bus.wb_addr_o  = wb_addr_q;
  assign bus.wb_data_o  = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_regfile : directed vector bench for wb_regfile                        |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_wb_regfile;

  logic clk_i;
  logic rst_ni;
  int   total;
  int   bad;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_valid;
    logic [4:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    bus.reg_we_i   = we;
    bus.wr_addr_i  = wa;
    bus.rd_wdata_i = wd;
    bus.raddr_a_i  = ra;
    bus.raddr_b_i  = rb;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // Rows are applied after an edge and checked before the next one.
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0, 32'h12345678, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 5'd0, 32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0};
    vecs[4] = '{1'b1, 5'd7, 32'h1,        5'd7, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 32'h0};
    vecs[5] = '{1'b1, 5'd7, 32'h2,        5'd7, 5'd7, 32'h1,        32'h1,        1'b1, 5'd7, 32'h1};
    vecs[6] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 32'h2,        32'hDEADBEEF, 1'b1, 5'd7, 32'h2};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 32'h2,        32'h0,        1'b0, 5'd0, 32'h0};

    rst_ni = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    tick();
    rst_ni = 1'b1;

    // Reset state of every register on both ports.
    check("reset_wb_valid", {31'b0, bus.wb_valid_o}, 32'h0);
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(k), 5'(31 - k));
      #1;
      check("reset_rd_a", bus.rdata_a_o, 32'h0);
      check("reset_rd_b", bus.rdata_b_o, 32'h0);
    end
    tick();

    // Basic write, x0 guard, back-to-back same register.
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].ra, vecs[v].rb);
      #1;
      check($sformatf("vec%0d_rd_a", v), bus.rdata_a_o, vecs[v].exp_a);
      check($sformatf("vec%0d_rd_b", v), bus.rdata_b_o, vecs[v].exp_b);
      check($sformatf("vec%0d_wb_valid", v), {31'b0, bus.wb_valid_o}, {31'b0, vecs[v].exp_valid});
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d_wb_addr", v), {27'b0, bus.wb_addr_o}, {27'b0, vecs[v].exp_wb_addr});
        check($sformatf("vec%0d_wb_data", v), bus.wb_data_o, vecs[v].exp_wb_data);
      end
      tick();
    end

    // Streaming writes r1..r31, reading the previous two results each cycle.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i * 32'h11), 5'(i - 1), (i >= 2) ? 5'(i - 2) : 5'd0);
      #1;
      check("stream_rd_a", bus.rdata_a_o, 32'((i - 1) * 32'h11));
      check("stream_rd_b", bus.rdata_b_o, (i >= 2) ? 32'((i - 2) * 32'h11) : 32'h0);
      if (i > 1) begin
        check("stream_wb_valid", {31'b0, bus.wb_valid_o}, 32'h1);
      end
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd30);
    #1;
    check("stream_tail_a", bus.rdata_a_o, 32'(31 * 32'h11));
    check("stream_tail_b", bus.rdata_b_o, 32'(30 * 32'h11));
    tick();
    for (int k = 0; k < 32; k++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(k), 5'(k));
      #1;
      check("sweep_rd_a", bus.rdata_a_o, 32'(k * 32'h11));
      check("sweep_rd_b", bus.rdata_b_o, 32'(k * 32'h11));
    end
    check("sweep_wb_valid", {31'b0, bus.wb_valid_o}, 32'h0);

    // Reset arriving while a write is pending discards it.
    drive(1'b1, 5'd9, 32'hAA, 5'd9, 5'd5);
    tick();
    check("rst_mid_pending", {31'b0, bus.wb_valid_o}, 32'h1);
    rst_ni = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
    tick();
    rst_ni = 1'b1;
    #1;
    check("rst_mid_wb_valid", {31'b0, bus.wb_valid_o}, 32'h0);
    check("rst_mid_r9", bus.rdata_a_o, 32'h0);
    check("rst_mid_r5", bus.rdata_b_o, 32'h0);
    tick();
    check("rst_mid_r9_later", bus.rdata_a_o, 32'h0);
    check("rst_mid_wb_data", bus.wb_data_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
